// File: rtl/arilogcal_seq.sv
// Multi-cycle calculator: shift-add multiply or restoring divide, then iterative
// double-dabble to BCD display codes. ARILOGCAL_LZB_EN enables leading-zero blanking.
module arilogcal_seq #(
  parameter int WIDTH      = 8,
  parameter int RES_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    ac,
  input  logic [WIDTH-1:0]        opt_a,
  input  logic [WIDTH-1:0]        opt_b,
  input  logic [2:0]              do_opt,
  input  logic                    equal_to,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    neg,
  output logic [5*RES_DIGITS-1:0] res_digits
);

  localparam int RW = 2 * WIDTH;
  localparam int ND = RES_DIGITS + 1;
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(RW + 1);

  localparam logic [4:0] CODE_E     = 5'd14;
  localparam logic [4:0] CODE_R     = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_CONV,
    S_PUB,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic                    eq_q, eq_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [2:0]              op_q, op_d;
  logic [RW-1:0]           work_q, work_d;
  logic [RW-1:0]           bin_q, bin_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic                    ovf_q, ovf_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    neg_pend_q, neg_pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    neg_q, neg_d;
  logic [5*RES_DIGITS-1:0] digits_q, digits_d;

  logic                    start;
  logic                    cap_err;
  logic                    multi;
  logic                    last_calc;
  logic                    last_conv;
  logic [WIDTH:0]          mul_sum;
  logic [RW-1:0]           mul_next;
  logic [WIDTH:0]          div_sh;
  logic [WIDTH:0]          div_trial;
  logic                    div_ge;
  logic [RW-1:0]           div_next;
  logic [RW-1:0]           calc_res;
  logic [BW-1:0]           bcd_adj;
  logic [BW-1:0]           bcd_next;
  logic                    ovf_next;
  logic                    conv_over;
  logic [5*RES_DIGITS-1:0] pub_digits;
  logic [5*RES_DIGITS-1:0] err_digits;

  assign start     = equal_to && !eq_q && (state_q == S_IDLE);
  assign cap_err   = (do_opt == 3'd0) ||
                     (((do_opt == 3'd3) || (do_opt == 3'd7)) && (opt_b == '0));
  assign multi     = (op_q == 3'd2) || (op_q == 3'd3) || (op_q == 3'd7);
  assign last_calc = !multi || (cnt_q == CW'(WIDTH - 1));
  assign last_conv = (cnt_q == CW'(RW - 1));

  // Multiplier: work = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, work_q[RW-1:WIDTH]} + {1'b0, (work_q[0] ? a_q : '0)};
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Divider: work = {remainder, quotient}, shifted left each step.
  assign div_sh    = {work_q[RW-1:WIDTH], work_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, b_q};
  assign div_ge    = (div_sh >= {1'b0, b_q});
  assign div_next  = div_ge ? {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1}
                            : {div_sh[WIDTH-1:0],    work_q[WIDTH-2:0], 1'b0};

  always_comb begin
    calc_res = '0;
    case (op_q)
      3'd1: calc_res = RW'(a_q) + RW'(b_q);
      3'd2: calc_res = mul_next;
      3'd3: calc_res = {{WIDTH{1'b0}}, div_next[WIDTH-1:0]};
      3'd4: calc_res[0] = (a_q != '0) && (b_q != '0);
      3'd5: calc_res[0] = (a_q != '0) || (b_q != '0);
      3'd6: calc_res = (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
      3'd7: calc_res = {{WIDTH{1'b0}}, div_next[RW-1:WIDTH]};
      default: calc_res = '0;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A bit carried out of the top digit also means the value cannot be displayed.
  assign bcd_next  = {bcd_adj[BW-2:0], bin_q[RW-1]};
  assign ovf_next  = ovf_q | bcd_adj[BW-1];
  assign conv_over = ovf_next || (bcd_next[BW-1 -: 4] != 4'd0);

`ifdef ARILOGCAL_LZB_EN
  logic seen;
  always_comb begin
    pub_digits = '0;
    seen       = 1'b0;
    for (int i = RES_DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      pub_digits[5*i +: 5] = (seen || (i == 0)) ? {1'b0, bcd_q[4*i +: 4]} : CODE_BLANK;
    end
  end
`else
  always_comb begin
    pub_digits = '0;
    for (int i = 0; i < RES_DIGITS; i++) begin
      pub_digits[5*i +: 5] = {1'b0, bcd_q[4*i +: 4]};
    end
  end
`endif

  always_comb begin
    err_digits        = {RES_DIGITS{CODE_BLANK}};
    err_digits[14:0]  = {CODE_E, CODE_R, CODE_R};
  end

  always_ff @(posedge clk) begin
    if (ac) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = cap_err ? S_ERR : S_CALC;
      S_CALC: if (last_calc) state_d = S_CONV;
      S_CONV: if (last_conv) state_d = conv_over ? S_ERR : S_PUB;
      S_PUB:  state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eq_d       = equal_to;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    work_d     = work_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    done_d     = 1'b0;
    err_d      = err_q;
    neg_d      = neg_q;
    digits_d   = digits_q;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = opt_a;
          b_d        = opt_b;
          op_d       = do_opt;
          cnt_d      = '0;
          neg_pend_d = 1'b0;
          work_d     = (do_opt == 3'd2) ? {{WIDTH{1'b0}}, opt_b} : {{WIDTH{1'b0}}, opt_a};
        end
      end
      S_CALC: begin
        work_d = (op_q == 3'd2) ? mul_next : div_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_calc) begin
          bin_d      = calc_res;
          bcd_d      = '0;
          ovf_d      = 1'b0;
          cnt_d      = '0;
          neg_pend_d = (op_q == 3'd6) && (a_q < b_q);
        end
      end
      S_CONV: begin
        bcd_d = bcd_next;
        ovf_d = ovf_next;
        bin_d = {bin_q[RW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      S_PUB: begin
        digits_d = pub_digits;
        neg_d    = neg_pend_q;
        err_d    = 1'b0;
        done_d   = 1'b1;
      end
      S_ERR: begin
        digits_d = err_digits;
        neg_d    = 1'b0;
        err_d    = 1'b1;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ac) begin
      eq_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      work_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      neg_q      <= 1'b0;
      digits_q   <= {RES_DIGITS{CODE_BLANK}};
    end else begin
      eq_q       <= eq_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      work_q     <= work_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      neg_q      <= neg_d;
      digits_q   <= digits_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign neg        = neg_q;
  assign res_digits = digits_q;

endmodule

// File: tb/tb_arilogcal_seq.sv
// Self-checking bench for arilogcal_seq against an arithmetic reference model.
module tb_arilogcal_seq;
  localparam int W  = 8;
  localparam int RD = 5;

  logic            clk = 1'b0;
  logic            ac;
  logic [W-1:0]    opt_a;
  logic [W-1:0]    opt_b;
  logic [2:0]      do_opt;
  logic            equal_to;
  logic            busy;
  logic            done;
  logic            err;
  logic            neg;
  logic [5*RD-1:0] res_digits;

  int total = 0;
  int bad   = 0;

  arilogcal_seq #(.WIDTH(W), .RES_DIGITS(RD)) dut (
    .clk        (clk),
    .ac         (ac),
    .opt_a      (opt_a),
    .opt_b      (opt_b),
    .do_opt     (do_opt),
    .equal_to   (equal_to),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .neg        (neg),
    .res_digits (res_digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5*RD-1:0] model_digits(input longint v, input bit e);
    logic [5*RD-1:0] r;
    longint p;
    r = '0;
    if (e) begin
      for (int i = 0; i < RD; i++) r[5*i +: 5] = 5'd17;
      r[14:10] = 5'd14;
      r[9:5]   = 5'd16;
      r[4:0]   = 5'd16;
    end else begin
      p = 1;
      for (int i = 0; i < RD; i++) begin
        r[5*i +: 5] = 5'((v / p) % 10);
`ifdef ARILOGCAL_LZB_EN
        if (i > 0 && v < p) r[5*i +: 5] = 5'd17;
`endif
        p = p * 10;
      end
    end
    return r;
  endfunction

  task automatic model(input int a, input int b, input int op,
                       output longint v, output bit e, output bit n, output int lat);
    longint lim;
    v = 0; e = 1'b0; n = 1'b0; lat = 2*W + 2;
    case (op)
      1: v = a + b;
      2: begin v = longint'(a) * b; lat = 3*W + 1; end
      3: if (b == 0) begin e = 1'b1; lat = 1; end else begin v = a / b; lat = 3*W + 1; end
      4: v = (a != 0 && b != 0) ? 1 : 0;
      5: v = (a != 0 || b != 0) ? 1 : 0;
      6: begin v = (a >= b) ? a - b : b - a; n = (a < b); end
      7: if (b == 0) begin e = 1'b1; lat = 1; end else begin v = a % b; lat = 3*W + 1; end
      default: begin e = 1'b1; lat = 1; end
    endcase
    lim = 1;
    for (int i = 0; i < RD; i++) lim = lim * 10;
    if (!e && v >= lim) e = 1'b1;
    if (e) n = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int op);
    longint v; bit e; bit n; int lat; int k; bit got; bit busy_ok;
    model(a, b, op, v, e, n, lat);
    @(negedge clk);
    opt_a = W'(a); opt_b = W'(b); do_opt = 3'(op); equal_to = 1'b0;
    @(negedge clk);
    equal_to = 1'b1;
    @(posedge clk);
    #1;
    check("busy_at_capture", 64'(busy), 64'(1));
    @(negedge clk);
    opt_a = W'($urandom); opt_b = W'($urandom); do_opt = 3'($urandom);
    k = 0; got = 1'b0; busy_ok = 1'b1;
    while (k < 200 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check($sformatf("latency op%0d a%0d b%0d", op, a, b), 64'(got ? k : -1), 64'(lat));
    check("busy_until_publish", 64'(busy_ok), 64'(1));
    check("busy_at_publish", 64'(busy), 64'(0));
    check($sformatf("digits op%0d a%0d b%0d", op, a, b), 64'(res_digits), 64'(model_digits(v, e)));
    check("err", 64'(err), 64'(e));
    check("neg", 64'(neg), 64'(n));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int nd; int a; int b; int op; bit busy_seen; longint v; bit e; bit n; int lat;
    ac = 1'b1; equal_to = 1'b0; opt_a = '0; opt_b = '0; do_opt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_neg", 64'(neg), 64'(0));
    check("reset_digits", 64'(res_digits), 64'({RD{5'd17}}));

    // Reset coinciding with a start edge: no capture.
    @(negedge clk);
    ac = 1'b1; equal_to = 1'b1; opt_a = 8'd1; opt_b = 8'd1; do_opt = 3'd1;
    @(posedge clk);
    #1;
    check("reset_wins_busy", 64'(busy), 64'(0));
    @(negedge clk);
    ac = 1'b0; equal_to = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wins_idle", 64'(busy), 64'(0));

    run_op(200, 100, 1);
    run_op(255, 255, 2);
    run_op(3, 4, 1);
    run_op(7, 0, 3);
    run_op(7, 5, 0);
    run_op(5, 9, 6);
    run_op(9, 5, 6);
    run_op(23, 5, 7);
    run_op(23, 5, 3);
    run_op(0, 3, 4);
    run_op(0, 3, 5);
    run_op(255, 1, 3);
    run_op(4, 0, 7);

    // equal_to left high after the last run: no further start.
    nd = 0; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
      if (busy) busy_seen = 1'b1;
    end
    check("held_high_no_done", 64'(nd), 64'(0));
    check("held_high_no_busy", 64'(busy_seen), 64'(0));

    for (int i = 0; i < 20; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      run_op(a, b, op);
    end

    // Re-trigger while busy is ignored.
    model(12, 34, 2, v, e, n, lat);
    @(negedge clk);
    opt_a = 8'd12; opt_b = 8'd34; do_opt = 3'd2; equal_to = 1'b0;
    @(negedge clk);
    equal_to = 1'b1;
    @(posedge clk);
    nd = 0;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
      if (i == 3) equal_to = 1'b0;
      if (i == 5) equal_to = 1'b1;
    end
    check("retrigger_one_done", 64'(nd), 64'(1));
    check("retrigger_digits", 64'(res_digits), 64'(model_digits(v, e)));

    // Reset in the middle of CALC aborts without publishing.
    @(negedge clk);
    opt_a = 8'd255; opt_b = 8'd255; do_opt = 3'd2; equal_to = 1'b0;
    @(negedge clk);
    equal_to = 1'b1;
    @(posedge clk);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    ac = 1'b1; equal_to = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_err", 64'(err), 64'(0));
    check("abort_digits", 64'(res_digits), 64'({RD{5'd17}}));
    ac = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("abort_no_publish", 64'(nd), 64'(0));
    check("abort_digits_hold", 64'(res_digits), 64'({RD{5'd17}}));

    run_op(99, 99, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
